// File: rtl/des_arb_pkg.sv
// Shared types and constants for the DES core arbiter slice.
package des_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int DES_TEXT_W          = 64;
  localparam int DES_LATENCY_DEFAULT = 17;

endpackage

// File: rtl/des_core_arbiter_if.sv
// Bundle of request, DES core and response signals around the arbiter.
// Debug taps expose the arbiter FSM state and round-robin pointer.
interface des_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import des_arb_pkg::*;

  // Handshakes: a request is taken on the single cycle req_ready[i] is high
  // while req_valid[i] is high; a response transfers on any cycle where
  // rsp_valid and rsp_ready are both high, and rsp_* hold until then.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_addr;
  logic [DES_TEXT_W*NUM_REQ-1:0] req_text;

  logic                  des_cs_bar;
  logic                  des_addr;
  logic [DES_TEXT_W-1:0] des_plain;
  logic [DES_TEXT_W-1:0] des_cipher;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [DES_TEXT_W-1:0] rsp_text;
  logic                  busy;

  arb_state_e            dbg_state;
  logic [ID_W-1:0]       dbg_rr_ptr;

  modport master (
    output req_valid, req_addr, req_text, des_cipher, rsp_ready,
    input  req_ready, des_cs_bar, des_addr, des_plain,
           rsp_valid, rsp_id, rsp_text, busy, dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  req_valid, req_addr, req_text, des_cipher, rsp_ready,
    output req_ready, des_cs_bar, des_addr, des_plain,
           rsp_valid, rsp_id, rsp_text, busy, dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/des_core_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  always_comb begin
    logic found;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/des_core_arbiter.sv
// Round-robin arbiter sharing one fixed-latency DES core among NUM_REQ requesters.
// Optional: define DES_ARB_PRIO0_EN to give requester 0 strict priority.
module des_core_arbiter
  import des_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DES_LATENCY = DES_LATENCY_DEFAULT
) (
  input logic          CLK,
  input logic          RST,
  des_core_arbiter_if.slave bus
);

  localparam int LAT_W = $clog2(DES_LATENCY + 1);

  arb_state_e            state_q;
  logic [NUM_REQ-1:0]    req_ready_q;
  logic                  des_cs_bar_q;
  logic                  des_addr_q;
  logic [DES_TEXT_W-1:0] des_plain_q;
  logic                  rsp_valid_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DES_TEXT_W-1:0] rsp_text_q;
  logic                  busy_q;
  logic [ID_W-1:0]       cur_id_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       rr_ptr_d;
  logic [LAT_W-1:0]      lat_cnt_q;

  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] rr_oh;
  logic [ID_W-1:0]    rr_idx;
  logic               rr_any;
  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_rr_pick (
    .req_i     (pick_req),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (rr_oh),
    .gnt_idx_o (rr_idx),
    .any_o     (rr_any)
  );

`ifdef DES_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign pick_req = {bus.req_valid[NUM_REQ-1:1], 1'b0};
  assign win_oh   = bus.req_valid[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : rr_oh;
  assign win_idx  = bus.req_valid[0] ? '0 : rr_idx;
  assign win_any  = bus.req_valid[0] | rr_any;
`else
  assign pick_req = bus.req_valid;
  assign win_oh   = rr_oh;
  assign win_idx  = rr_idx;
  assign win_any  = rr_any;
`endif

  assign rr_ptr_d = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      req_ready_q  <= '0;
      des_cs_bar_q <= 1'b1;
      des_addr_q   <= 1'b0;
      des_plain_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_text_q   <= '0;
      busy_q       <= 1'b0;
      cur_id_q     <= '0;
      rr_ptr_q     <= '0;
      lat_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            req_ready_q <= win_oh;
            des_plain_q <= bus.req_text[int'(win_idx)*DES_TEXT_W +: DES_TEXT_W];
            des_addr_q  <= bus.req_addr[win_idx];
            cur_id_q    <= win_idx;
            busy_q      <= 1'b1;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          req_ready_q  <= '0;
          des_cs_bar_q <= 1'b0;
`ifdef DES_ARB_PRIO0_EN
          if (cur_id_q != '0) rr_ptr_q <= rr_ptr_d;
`else
          rr_ptr_q     <= rr_ptr_d;
`endif
          lat_cnt_q    <= '0;
          state_q      <= RUN;
        end
        RUN: begin
          des_cs_bar_q <= 1'b1;
          // Count ends one short of the latency: the capture edge is the last cycle.
          if (lat_cnt_q == LAT_W'(DES_LATENCY - 1)) begin
            rsp_text_q  <= bus.des_cipher;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.des_cs_bar = des_cs_bar_q;
  assign bus.des_addr   = des_addr_q;
  assign bus.des_plain  = des_plain_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_text   = rsp_text_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_des_core_arbiter.sv
// Directed bench for des_core_arbiter with a behavioural fixed-latency DES stand-in.
// Build with DES_ARB_PRIO0_EN defined to exercise the requester-0 priority mode.
module tb_des_core_arbiter;
  import des_arb_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  des_core_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus();

  des_core_arbiter #(.NUM_REQ(4), .ID_W(2), .DES_LATENCY(17)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Stand-in core: result is only presented on the single cycle it is due.
  logic [4:0]  core_cnt = '0;
  logic [63:0] core_res = '0;
  always @(posedge CLK) begin
    if (!bus.des_cs_bar) begin
      core_cnt <= 5'd1;
      core_res <= bus.des_addr ? ~bus.des_plain
                               : {bus.des_plain[31:0], bus.des_plain[63:32]};
    end else if (core_cnt != 5'd0 && core_cnt != 5'd31) begin
      core_cnt <= core_cnt + 5'd1;
    end
  end
  assign bus.des_cipher = (core_cnt == 5'd16) ? core_res
                                              : {48'hDEAD_BEEF_0000, 11'd0, core_cnt};

  logic [63:0] text_tab [4];
  logic [63:0] res_tab  [4];
  logic [1:0]  exp_q [$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (|bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g;
    int   prev;
    logic ok;
    logic saw_rsp;
    logic [1:0] e;

    text_tab[0] = 64'h1111_2222_3333_4444;  res_tab[0] = 64'h3333_4444_1111_2222;
    text_tab[1] = 64'h0F0F_0000_FFFF_1234;  res_tab[1] = 64'hF0F0_FFFF_0000_EDCB;
    text_tab[2] = 64'h0123_4567_89AB_CDEF;  res_tab[2] = 64'h89AB_CDEF_0123_4567;
    text_tab[3] = 64'hA5A5_5A5A_0000_0001;  res_tab[3] = 64'h5A5A_A5A5_FFFF_FFFE;

    bus.req_valid = 4'b0000;
    bus.req_addr  = 4'b1010;
    bus.req_text  = {text_tab[3], text_tab[2], text_tab[1], text_tab[0]};
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_cs_bar", 64'(bus.des_cs_bar), 64'h1);
    check("rst_des_addr", 64'(bus.des_addr), 64'h0);
    check("rst_des_plain", bus.des_plain, 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'h0);
    check("rst_rsp_text", bus.rsp_text, 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    RST = 1'b0;
    tick();
    check("idle_no_req_state", 64'(bus.dbg_state), 64'(IDLE));
    check("idle_no_req_ptr", 64'(bus.dbg_rr_ptr), 64'h0);

    // Single request from requester 2
    bus.req_valid = 4'b0100;
    tick();
    g = cyc;
    check("t1_ready", 64'(bus.req_ready), 64'h4);
    check("t1_plain", bus.des_plain, 64'h0123_4567_89AB_CDEF);
    check("t1_addr", 64'(bus.des_addr), 64'h0);
    check("t1_busy", 64'(bus.busy), 64'h1);
    check("t1_cs_before", 64'(bus.des_cs_bar), 64'h1);
    bus.req_valid = 4'b0000;
    tick();
    check("t1_ready_pulse", 64'(bus.req_ready), 64'h0);
    check("t1_cs_low", 64'(bus.des_cs_bar), 64'h0);
    tick();
    check("t1_cs_high", 64'(bus.des_cs_bar), 64'h1);
    tick_to(g + 17);
    check("t1_rsp_not_early", 64'(bus.rsp_valid), 64'h0);
    tick();
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("t1_rsp_id", 64'(bus.rsp_id), 64'h2);
    check("t1_rsp_text", bus.rsp_text, 64'h89AB_CDEF_0123_4567);
    check("t1_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h3);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t1_rsp_done", 64'(bus.rsp_valid), 64'h0);
    check("t1_idle_busy", 64'(bus.busy), 64'h0);

    // Backpressure on requester 1's response; requester 3 waits meanwhile
    bus.req_valid = 4'b0010;
    tick();
    g = cyc;
    check("t3_ready", 64'(bus.req_ready), 64'h2);
    bus.req_valid = 4'b1000;
    tick_to(g + 18);
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("t3_rsp_id", 64'(bus.rsp_id), 64'h1);
    check("t3_rsp_text", bus.rsp_text, res_tab[1]);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", 64'(bus.rsp_valid), 64'h1);
      check("t3_hold_id", 64'(bus.rsp_id), 64'h1);
      check("t3_hold_text", bus.rsp_text, res_tab[1]);
      check("t3_hold_no_ready", 64'(bus.req_ready), 64'h0);
      check("t3_hold_busy", 64'(bus.busy), 64'h1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t3_hs_valid", 64'(bus.rsp_valid), 64'h0);
    check("t3_hs_state", 64'(bus.dbg_state), 64'(IDLE));
    check("t3_hs_no_same_cycle_grant", 64'(bus.req_ready), 64'h0);
    check("t3_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h2);
    tick();
    g = cyc;
    check("t3_next_grant", 64'(bus.req_ready), 64'h8);
    bus.req_valid = 4'b0000;
    tick_to(g + 18);
    check("t3b_rsp_id", 64'(bus.rsp_id), 64'h3);
    check("t3b_rsp_text", bus.rsp_text, res_tab[3]);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Requester 3 withdraws while requester 1 runs; requester 2 then wins
    bus.req_valid = 4'b1010;
    tick();
    g = cyc;
    check("t6_grant1", 64'(bus.req_ready), 64'h2);
    bus.req_valid = 4'b1000;
    tick_to(g + 2);
    bus.req_valid = 4'b0100;
    tick_to(g + 18);
    check("t6_rsp_id", 64'(bus.rsp_id), 64'h1);
    check("t6_rsp_text", bus.rsp_text, res_tab[1]);
    check("t6_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h2);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    g = cyc;
    check("t6_grant2", 64'(bus.req_ready), 64'h4);
    bus.req_valid = 4'b0000;

    // Reset in the middle of the run
    tick_to(g + 9);
    check("t4_pre_state", 64'(bus.dbg_state), 64'(RUN));
    RST = 1'b1;
    #1;
    check("t4_state", 64'(bus.dbg_state), 64'(IDLE));
    check("t4_cs_bar", 64'(bus.des_cs_bar), 64'h1);
    check("t4_plain", bus.des_plain, 64'h0);
    check("t4_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("t4_rsp_text", bus.rsp_text, 64'h0);
    check("t4_busy", 64'(bus.busy), 64'h0);
    check("t4_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h0);
    tick();
    RST = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("t4_no_rsp_after_reset", 64'(saw_rsp), 64'h0);

`ifdef DES_ARB_PRIO0_EN
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
`else
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    // Saturated requests with an always-ready sink
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    prev = 0;
    for (int k = 0; exp_q.size() > 0; k++) begin
      wait_grant(40, ok);
      check("t2_grant_seen", 64'(ok), 64'h1);
      e = exp_q.pop_front();
      check("t2_grant_onehot", 64'(bus.req_ready), 64'(4'b0001 << e));
      if (k > 0) check("t2_grant_spacing", 64'(cyc - prev), 64'd20);
      prev = cyc;
`ifdef DES_ARB_PRIO0_EN
      if (k == 2) bus.req_valid = 4'b1110;
`endif
      if (exp_q.size() == 0) bus.req_valid = 4'b0000;
      tick_to(prev + 18);
      check("t2_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      check("t2_rsp_id", 64'(bus.rsp_id), 64'(e));
      check("t2_rsp_text", bus.rsp_text, res_tab[e]);
    end
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    check("end_idle", 64'(bus.dbg_state), 64'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_core_arbiter.md
Name: des_core_arbiter

Overview:
Shares one DES core among NUM_REQ independent requesters using round-robin arbitration. Each request is 64-bit text plus an encrypt/decrypt select. The arbiter drives the core's chip-select and address, counts the core's fixed latency, captures the result, and returns it with the requester ID over a valid/ready response channel. It sits between the host-side request sources and the DES core, ahead of the RS232 byte sender.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must equal clog2(NUM_REQ)
DES_LATENCY, 17, cycles from chip-select assertion to valid core output

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_addr  in  NUM_REQ  per-requester encrypt(0)/decrypt(1) select
req_text  in  64*NUM_REQ  per-requester text; requester i occupies bits [64i+63:64i]
des_cs_bar  out  1  DES chip select, active-low
des_addr  out  1  DES mode select
des_plain  out  64  DES input text
des_cipher  in  64  DES output text
rsp_valid  out  1  response available
rsp_ready  in  1  downstream accepts response
rsp_id  out  ID_W  requester that owns the response
rsp_text  out  64  DES result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous on RST, active-high, clock is CLK. All outputs are registered.
- Reset values: state=IDLE, des_cs_bar=1, des_addr=0, des_plain=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_text=0, busy=0, rr_ptr=0, lat_cnt=0.
- FSM states: IDLE, GRANT, RUN, RESP.
- IDLE, when any req_valid is set:
  - Choose the winner by round-robin, searching from rr_ptr upward with wrap-around.
  - Latch the winner's text, address and ID into des_plain, des_addr and cur_id.
  - Pulse req_ready[winner] for one cycle; this is the handshake.
  - Go to GRANT. No other requester sees ready.
- GRANT:
  - Drive des_cs_bar=0 for exactly one cycle.
  - Set rr_ptr = winner+1, mod NUM_REQ.
  - Set lat_cnt=0 and go to RUN.
- RUN:
  - des_cs_bar=1; des_plain and des_addr are held stable.
  - lat_cnt increments each cycle.
  - When lat_cnt == DES_LATENCY-1: capture des_cipher into rsp_text, set rsp_id=cur_id, set rsp_valid=1, go to RESP.
  - Total latency from the req_ready pulse to rsp_valid is DES_LATENCY+1 cycles.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. A new grant can issue on the next cycle, so there is one idle cycle between jobs.
- req_valid changes outside IDLE are ignored; requests are never preempted.
- A requester that deasserts req_valid before being granted is not served.
- If all req_valid are zero, the FSM stays in IDLE and rr_ptr is unchanged.
- Simultaneous rsp handshake and new req_valid: the grant happens one cycle later, from IDLE.
- RST asserted mid-operation: the job is dropped with no response and everything returns to reset values. A stale core output is never captured because lat_cnt restarts from 0.
- lat_cnt is clog2(DES_LATENCY+1) bits wide; wrap-around is impossible.

Optional Feature:
DES_ARB_PRIO0_EN:
- Defined: requester 0 has strict priority. Whenever req_valid[0]=1 in IDLE, it wins regardless of rr_ptr, and rr_ptr is not updated on its grants. The remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin across all NUM_REQ requesters.

Decomposition:
- Package des_arb_pkg holds:
  - state enum: IDLE=2'd0, GRANT=2'd1, RUN=2'd2, RESP=2'd3
  - DES_TEXT_W=64
  - default DES_LATENCY=17
- One sub-module, rr_pick:
  - Purely combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant, grant index, any.
  - Used by the FSM in IDLE.

Test Plan:
1. Reset then single request: req_valid=4'b0100, req_text[2]=64'h0123456789ABCDEF, addr=0 -> req_ready=4'b0100 for 1 cycle; des_cs_bar low 1 cycle; rsp_valid 18 cycles after ready; rsp_id=2; rsp_text=des_cipher at capture.
2. All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each job spans 20 cycles from grant to next grant.
3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_text/rsp_id stable; no new req_ready; busy=1; handshake on cycle 11 returns to IDLE.
4. Reset mid-RUN (lat_cnt=8) -> all outputs at reset values immediately, no rsp_valid; next request gets a fresh DES_LATENCY count and rr_ptr=0.
5. With DES_ARB_PRIO0_EN: req_valid=4'b1111 held -> requester 0 wins every arbitration. Then drop req 0 -> order 1,2,3 rotates.
6. Requester 3 deasserts valid while requester 1 is in RUN -> requester 3 is never granted; rr_ptr=2 selects requester 2 next if it is valid.
